// File: rtl/instr_encoder_loader.sv
// KGP-RISC field-bundle encoder that streams 32-bit instruction words into instruction memory.
// Optional build macro ENC_RANGE_CHECK_EN rejects bundles whose fields overflow their encoded width.
module instr_encoder_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        opcode,
   input  logic [3:0]        func_code,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [31:0]       imm,
   input  logic [31:0]       label,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              wrap,
   output logic [ADDR_W:0]   word_count
);

`ifdef ENC_RANGE_CHECK_EN
   localparam bit RangeCheck = 1'b1;
`else
   localparam bit RangeCheck = 1'b0;
`endif

   localparam logic [ADDR_W:0] CountMax = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr;
   logic              last_q;
   logic [31:0]       enc_word;
   logic              op_ok;
   logic              range_ok;
   logic              legal;
   logic              accept;

   assign accept = in_valid && in_ready;

   // Pack the fields by format tag and decide whether the bundle may be written at all.
   always_comb begin
      enc_word        = '0;
      op_ok           = 1'b1;
      range_ok        = 1'b1;
      enc_word[31:29] = opcode;
      case (opcode)
         3'b000: begin
            enc_word[28:24] = rs;
            enc_word[23:19] = rt;
            enc_word[18:14] = imm[4:0];
            enc_word[13:10] = func_code;
            range_ok        = (imm[31:5] == '0);
         end
         3'b001: begin
            enc_word[28:24] = rs;
            enc_word[23:4]  = imm[19:0];
            enc_word[3:0]   = func_code;
            range_ok        = (&imm[31:19]) || (~|imm[31:19]);
         end
         3'b010: begin
            enc_word[28:24] = rs;
            enc_word[23:19] = rt;
            enc_word[18:1]  = imm[17:0];
            enc_word[0]     = func_code[0];
            range_ok        = ((&imm[31:17]) || (~|imm[31:17])) && (func_code[3:1] == 3'b000);
         end
         3'b011: begin
            enc_word[28:4] = label[24:0];
            enc_word[3:0]  = func_code;
            range_ok       = (label[31:25] == '0);
         end
         3'b100: begin
            enc_word[28:24] = rs;
            enc_word[23:20] = func_code;
         end
         3'b101: begin
            enc_word[28:24] = rs;
            enc_word[23:4]  = label[19:0];
            enc_word[3:0]   = func_code;
            range_ok        = (label[31:20] == '0);
         end
         default: op_ok = 1'b0;
      endcase
      legal = op_ok && (range_ok || !RangeCheck);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD: begin
            if (accept) begin
               if (legal)        state_next = WRITE;
               else if (in_last) state_next = DONE;
            end
         end
         WRITE:   state_next = last_q ? DONE : LOAD;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr       <= '0;
         last_q     <= 1'b0;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         wrap       <= 1'b0;
         word_count <= '0;
      end else begin
         state    <= state_next;
         in_ready <= (state_next == LOAD);
         mem_we   <= (state_next == WRITE);
         busy     <= (state_next != IDLE);
         done     <= (state_next == DONE);
         err      <= (state == LOAD) && accept && !legal;

         if (state == IDLE && start) begin
            addr       <= base_addr;
            wrap       <= 1'b0;
            word_count <= '0;
         end

         if (state == LOAD && accept && legal) begin
            mem_wdata <= enc_word;
            mem_addr  <= addr;
            last_q    <= in_last;
         end

         // Address keeps rolling after a wrap; only the sticky flag records it.
         if (state == WRITE) begin
            addr <= addr + ADDR_W'(1);
            if (&addr) wrap <= 1'b1;
            if (word_count != CountMax) word_count <= word_count + (ADDR_W+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against a field-level encoding model.
// Honours ENC_RANGE_CHECK_EN the same way the design does.
module tb_instr_encoder_loader;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [2:0]    opcode = '0;
   logic [3:0]    func_code = '0;
   logic [4:0]    rs = '0;
   logic [4:0]    rt = '0;
   logic [31:0]   imm = '0;
   logic [31:0]   label = '0;
   logic          in_ready, mem_we, busy, done, err, wrap;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   word_count;

   int vectors = 0;
   int miscompares = 0;

   int m_addr, m_count;
   bit m_wrap;

   bit            g_we, g_err, g_to;
   logic [AW-1:0] g_addr;
   logic [31:0]   g_wdata;

   instr_encoder_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .opcode(opcode), .func_code(func_code), .rs(rs), .rt(rt), .imm(imm), .label(label),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err), .wrap(wrap), .word_count(word_count)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Word layout computed with shifts and modular truncation of each field.
   function automatic logic [31:0] enc_ref(input logic [2:0] op, input logic [3:0] f,
                                           input logic [4:0] s, input logic [4:0] t,
                                           input logic [31:0] im, input logic [31:0] lb);
      longint unsigned w;
      w = 64'(op) * 64'd536870912;
      case (op)
         3'd0: w += (64'(s) << 24) + (64'(t) << 19) + ((64'(im) % 64'd32) << 14) + (64'(f) << 10);
         3'd1: w += (64'(s) << 24) + ((64'(im) % 64'd1048576) << 4) + 64'(f);
         3'd2: w += (64'(s) << 24) + (64'(t) << 19) + ((64'(im) % 64'd262144) << 1) + (64'(f) % 64'd2);
         3'd3: w += ((64'(lb) % 64'd33554432) << 4) + 64'(f);
         3'd4: w += (64'(s) << 24) + (64'(f) << 20);
         3'd5: w += (64'(s) << 24) + ((64'(lb) % 64'd1048576) << 4) + 64'(f);
         default: w = 0;
      endcase
      return w[31:0];
   endfunction

   function automatic bit legal_ref(input logic [2:0] op, input logic [3:0] f,
                                    input logic [31:0] im, input logic [31:0] lb);
      if (op >= 3'd6) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
      case (op)
         3'd0: return im < 32'd32;
         3'd1: return ($signed(im) >= -524288) && ($signed(im) <= 524287);
         3'd2: return ($signed(im) >= -131072) && ($signed(im) <= 131071) && (f <= 4'd1);
         3'd3: return lb < 32'd33554432;
         3'd5: return lb < 32'd1048576;
         default: return 1'b1;
      endcase
`else
      return 1'b1;
`endif
   endfunction

   // Advances the model for one accepted bundle; returns the address it should land on.
   function automatic int model_write();
      int a;
      a = m_addr;
      if (m_addr == (1 << AW) - 1) m_wrap = 1'b1;
      m_addr = (m_addr + 1) % (1 << AW);
      if (m_count < (1 << AW)) m_count++;
      return a;
   endfunction

   task automatic open_session(input int base);
      start = 1'b1;
      base_addr = AW'(base);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      m_addr = base;
      m_count = 0;
      m_wrap = 1'b0;
   endtask

   // Presents one bundle and records what the DUT shows in the cycle after the accept edge.
   task automatic send(input logic [2:0] op, input logic [3:0] f, input logic [4:0] s,
                       input logic [4:0] t, input logic [31:0] im, input logic [31:0] lb,
                       input bit last);
      int n = 0;
      while (in_ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      g_to = (in_ready !== 1'b1);
      g_we = 1'b0; g_err = 1'b0; g_addr = '0; g_wdata = '0;
      if (!g_to) begin
         opcode = op; func_code = f; rs = s; rt = t; imm = im; label = lb;
         in_last = last; in_valid = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0; in_last = 1'b0;
         @(negedge clk);
         g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata; g_err = err;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({in_ready, mem_we, busy, done, err, wrap} !== 6'b0) begin
         miscompares++; $display("[TB] FAIL reset_flags: got %b expected 000000", {in_ready, mem_we, busy, done, err, wrap});
      end
      vectors++;
      if (mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
         miscompares++; $display("[TB] FAIL reset_data: got addr %h wdata %h count %0d expected zeros", mem_addr, mem_wdata, word_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_r_word();
      open_session(0);
      send(3'd0, 4'd4, 5'd1, 5'd2, 32'd3, 32'd0, 1'b1);
      vectors++;
      if (g_to || g_we !== 1'b1 || g_addr !== 10'd0) begin
         miscompares++; $display("[TB] FAIL r_write: got we %b addr %0d to %b expected we 1 addr 0", g_we, g_addr, g_to);
      end
      vectors++;
      if (g_wdata !== 32'h0110D000) begin
         miscompares++; $display("[TB] FAIL r_wdata: got %h expected 0110d000", g_wdata);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || word_count !== 11'd1) begin
         miscompares++; $display("[TB] FAIL r_done: got done %b count %0d expected done 1 count 1", done, word_count);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("[TB] FAIL r_idle: got busy %b done %b expected 0 0", busy, done);
      end
   endtask

   task automatic test_burst();
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h25FFFFF2; exp_w[1] = 32'h60000101; exp_w[2] = 32'h9F000000;
      open_session(0);
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: send(3'd1, 4'd2, 5'd5, 5'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
            1: send(3'd3, 4'd1, 5'd0, 5'd0, 32'd0, 32'h10, 1'b0);
            default: send(3'd4, 4'd0, 5'd31, 5'd0, 32'd0, 32'd0, 1'b1);
         endcase
         vectors++;
         if (g_to || g_we !== 1'b1 || g_addr !== AW'(i) || g_wdata !== exp_w[i]) begin
            miscompares++; $display("[TB] FAIL burst_word%0d: got we %b addr %0d wdata %h expected we 1 addr %0d wdata %h", i, g_we, g_addr, g_wdata, i, exp_w[i]);
         end
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || word_count !== 11'd3) begin
         miscompares++; $display("[TB] FAIL burst_done: got done %b count %0d expected 1 3", done, word_count);
      end
      @(negedge clk);
   endtask

   task automatic test_imm_boundary();
      bit lg;
      int ea;
      lg = legal_ref(3'd1, 4'd0, 32'h00080000, 32'd0);
      open_session(5);
      send(3'd1, 4'd0, 5'd0, 5'd0, 32'h00080000, 32'd0, 1'b0);
      if (lg) ea = model_write();
      vectors++;
      if (g_to || g_we !== lg || g_err !== !lg) begin
         miscompares++; $display("[TB] FAIL imm19_status: got we %b err %b expected we %b err %b", g_we, g_err, lg, !lg);
      end
      if (lg) begin
         vectors++;
         if (g_wdata !== 32'h20800000 || g_addr !== 10'd5) begin
            miscompares++; $display("[TB] FAIL imm19_word: got %h at %0d expected 20800000 at 5", g_wdata, g_addr);
         end
      end
      send(3'd4, 4'd3, 5'd7, 5'd0, 32'd0, 32'd0, 1'b1);
      ea = model_write();
      vectors++;
      if (g_we !== 1'b1 || g_addr !== AW'(ea)) begin
         miscompares++; $display("[TB] FAIL imm19_next_addr: got we %b addr %0d expected 1 %0d", g_we, g_addr, ea);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_wrap();
      open_session(1023);
      send(3'd0, 4'd1, 5'd2, 5'd3, 32'd4, 32'd0, 1'b0);
      vectors++;
      if (g_we !== 1'b1 || g_addr !== 10'd1023) begin
         miscompares++; $display("[TB] FAIL wrap_first: got we %b addr %0d expected 1 1023", g_we, g_addr);
      end
      send(3'd1, 4'd1, 5'd2, 5'd0, 32'd4, 32'd0, 1'b1);
      vectors++;
      if (g_we !== 1'b1 || g_addr !== 10'd0) begin
         miscompares++; $display("[TB] FAIL wrap_second: got we %b addr %0d expected 1 0", g_we, g_addr);
      end
      @(negedge clk);
      vectors++;
      if (wrap !== 1'b1 || word_count !== 11'd2 || done !== 1'b1) begin
         miscompares++; $display("[TB] FAIL wrap_flag: got wrap %b count %0d done %b expected 1 2 1", wrap, word_count, done);
      end
      @(negedge clk);
      open_session(3);
      vectors++;
      if (wrap !== 1'b0 || word_count !== 11'd0) begin
         miscompares++; $display("[TB] FAIL wrap_clear: got wrap %b count %0d expected 0 0", wrap, word_count);
      end
      send(3'd7, 4'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_illegal();
      open_session(100);
      start = 1'b1; base_addr = 10'd500;
      @(negedge clk);
      start = 1'b0;
      send(3'd7, 4'd0, 5'd1, 5'd1, 32'd0, 32'd0, 1'b0);
      vectors++;
      if (g_to || g_err !== 1'b1 || g_we !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("[TB] FAIL illegal_mid: got err %b we %b done %b expected 1 0 0", g_err, g_we, done);
      end
      send(3'd0, 4'd2, 5'd3, 5'd4, 32'd5, 32'd0, 1'b0);
      vectors++;
      if (g_we !== 1'b1 || g_addr !== 10'd100 || g_wdata !== enc_ref(3'd0, 4'd2, 5'd3, 5'd4, 32'd5, 32'd0)) begin
         miscompares++; $display("[TB] FAIL illegal_keep_addr: got we %b addr %0d wdata %h expected 1 100 %h", g_we, g_addr, g_wdata, enc_ref(3'd0, 4'd2, 5'd3, 5'd4, 32'd5, 32'd0));
      end
      send(3'd6, 4'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
      vectors++;
      if (g_err !== 1'b1 || g_we !== 1'b0 || done !== 1'b1 || word_count !== 11'd1) begin
         miscompares++; $display("[TB] FAIL illegal_last: got err %b we %b done %b count %0d expected 1 0 1 1", g_err, g_we, done, word_count);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("[TB] FAIL illegal_idle: got busy %b err %b done %b expected 0 0 0", busy, err, done);
      end
   endtask

   task automatic test_reset_midwrite();
      open_session(40);
      opcode = 3'd4; func_code = 4'd5; rs = 5'd9; in_last = 1'b1; in_valid = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      vectors++;
      if ({in_ready, mem_we, busy, done, err, wrap} !== 6'b0) begin
         miscompares++; $display("[TB] FAIL rstmid_flags: got %b expected 000000", {in_ready, mem_we, busy, done, err, wrap});
      end
      vectors++;
      if (mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
         miscompares++; $display("[TB] FAIL rstmid_data: got addr %h wdata %h count %0d expected zeros", mem_addr, mem_wdata, word_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (mem_we !== 1'b0 || busy !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rstmid_after: got we %b busy %b expected 0 0", mem_we, busy);
      end
      open_session(7);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("[TB] FAIL rstmid_restart: got in_ready %b expected 1", in_ready);
      end
      send(3'd7, 4'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int s = 0; s < 8; s++) begin
         int len;
         len = int'($urandom_range(1, 8));
         open_session(int'($urandom_range(0, (1 << AW) - 1)));
         for (int i = 0; i < len; i++) begin
            logic [2:0] op; logic [3:0] f; logic [4:0] r1, r2; logic [31:0] im, lb;
            bit lg, last;
            int ea;
            op = 3'($urandom_range(0, 7));
            f = 4'($urandom_range(0, 15));
            r1 = 5'($urandom); r2 = 5'($urandom);
            case ($urandom_range(0, 3))
               0: im = $urandom;
               1: im = $urandom_range(0, 40);
               2: im = 32'd0 - $urandom_range(1, 600000);
               default: im = $urandom_range(0, 600000);
            endcase
            lb = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 32'h02FFFFFF);
            last = (i == len - 1);
            lg = legal_ref(op, f, im, lb);
            send(op, f, r1, r2, im, lb, last);
            vectors++;
            if (g_to || g_we !== lg || g_err !== !lg) begin
               miscompares++; $display("[TB] FAIL rand_status s%0d w%0d op %0d: got we %b err %b to %b expected we %b err %b", s, i, op, g_we, g_err, g_to, lg, !lg);
            end
            if (lg) begin
               ea = model_write();
               vectors++;
               if (g_addr !== AW'(ea) || g_wdata !== enc_ref(op, f, r1, r2, im, lb)) begin
                  miscompares++; $display("[TB] FAIL rand_word s%0d w%0d op %0d: got %h at %0d expected %h at %0d", s, i, op, g_wdata, g_addr, enc_ref(op, f, r1, r2, im, lb), ea);
               end
            end
            if (last) begin
               if (lg) @(negedge clk);
               vectors++;
               if (done !== 1'b1 || word_count !== (AW+1)'(m_count) || wrap !== m_wrap) begin
                  miscompares++; $display("[TB] FAIL rand_end s%0d: got done %b count %0d wrap %b expected 1 %0d %b", s, done, word_count, wrap, m_count, m_wrap);
               end
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic test_saturation();
      bit any_to = 1'b0;
      int ea = 0;
      open_session(0);
      for (int i = 0; i <= (1 << AW); i++) begin
         send(3'd4, 4'd1, 5'd2, 5'd0, 32'd0, 32'd0, i == (1 << AW));
         ea = model_write();
         any_to |= g_to;
      end
      vectors++;
      if (any_to || g_we !== 1'b1 || g_addr !== AW'(ea)) begin
         miscompares++; $display("[TB] FAIL sat_last_word: got we %b addr %0d to %b expected 1 %0d", g_we, g_addr, any_to, ea);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || word_count !== (AW+1)'(m_count) || wrap !== 1'b1) begin
         miscompares++; $display("[TB] FAIL sat_count: got done %b count %0d wrap %b expected 1 %0d 1", done, word_count, wrap, m_count);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_r_word();
      test_burst();
      test_imm_boundary();
      test_wrap();
      test_illegal();
      test_reset_midwrite();
      test_random();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
